// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the serial (chunk-at-a-time) adder.
//   sadd_state_t : controller state encoding
//   nchunks()    : number of chunks an operand is split into
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } sadd_state_t;

  function automatic int unsigned nchunks(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple chain.
//   a, b  : addend bits
//   c     : carry in
//   sum   : sum bit
//   carry : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle unsigned adder: sum = a + b + cin, CHUNK bits per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled when not busy (IDLE or DONE)
//   a, b, cin  : operands, captured on the accepted start edge
//   busy       : high while the addition is in progress
//   done       : one-cycle pulse when sum/cout are valid
//   sum, cout  : result, held until the next accepted start
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NCH = nchunks(WIDTH, CHUNK);
  localparam int unsigned CW  = $clog2(NCH) + 1;

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_err
    $error("serial_adder: need 1<=CHUNK<=WIDTH and WIDTH%%CHUNK==0");
  end

  sadd_state_t      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  // Chunk select: shift the latched operands so the active chunk sits at bit 0.
  logic [31:0]      shamt;
  logic [WIDTH-1:0] a_shift, b_shift;
  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic [CHUNK:0]   c_chain;
  logic [WIDTH-1:0] chunk_mask;
  logic             last_chunk;

  assign shamt      = 32'(cnt_q) * 32'(CHUNK);
  assign a_shift    = a_q >> shamt;
  assign b_shift    = b_q >> shamt;
  assign a_chunk    = a_shift[CHUNK-1:0];
  assign b_chunk    = b_shift[CHUNK-1:0];
  assign chunk_mask = WIDTH'({CHUNK{1'b1}}) << shamt;
  assign last_chunk = (cnt_q == CW'(NCH - 1));

  assign c_chain[0] = carry_q;

  for (genvar i = 0; i < CHUNK; i++) begin : g_chain
    full_adder u_fa (
      .a     (a_chunk[i]),
      .b     (b_chunk[i]),
      .c     (c_chain[i]),
      .sum   (s_chunk[i]),
      .carry (c_chain[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new start just like IDLE so back-to-back ops lose no cycle.
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d   = (sum_q & ~chunk_mask) | ((WIDTH'(s_chunk) << shamt) & chunk_mask);
        carry_d = c_chain[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (last_chunk) begin
          cout_d  = c_chain[CHUNK];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: several parameterisations share one clock, reset and operand bus;
// each has its own start line. Directed vectors plus a short random sweep against a+b+cin.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a_i, b_i;
  logic        cin_i;
  logic [5:0]  start_v;
  logic [5:0]  busy_v, done_v, cout_v;
  logic [15:0] sum_w [6];

  logic [7:0]  s0, s1, s4, s5;
  logic [15:0] s2;
  logic [11:0] s3;

  // Per-instance configuration: (8,1) (8,4) (16,16) (12,3) (8,2) (8,8)
  int wid [6] = '{8, 8, 16, 12, 8, 8};
  int nch [6] = '{8, 2, 1, 4, 4, 1};

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .CHUNK(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_i[7:0]), .b(b_i[7:0]), .cin(cin_i),
    .busy(busy_v[0]), .done(done_v[0]), .sum(s0), .cout(cout_v[0]));
  serial_adder #(.WIDTH(8), .CHUNK(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_i[7:0]), .b(b_i[7:0]), .cin(cin_i),
    .busy(busy_v[1]), .done(done_v[1]), .sum(s1), .cout(cout_v[1]));
  serial_adder #(.WIDTH(16), .CHUNK(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_i), .b(b_i), .cin(cin_i),
    .busy(busy_v[2]), .done(done_v[2]), .sum(s2), .cout(cout_v[2]));
  serial_adder #(.WIDTH(12), .CHUNK(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a(a_i[11:0]), .b(b_i[11:0]), .cin(cin_i),
    .busy(busy_v[3]), .done(done_v[3]), .sum(s3), .cout(cout_v[3]));
  serial_adder #(.WIDTH(8), .CHUNK(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[4]), .a(a_i[7:0]), .b(b_i[7:0]), .cin(cin_i),
    .busy(busy_v[4]), .done(done_v[4]), .sum(s4), .cout(cout_v[4]));
  serial_adder #(.WIDTH(8), .CHUNK(8)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start_v[5]), .a(a_i[7:0]), .b(b_i[7:0]), .cin(cin_i),
    .busy(busy_v[5]), .done(done_v[5]), .sum(s5), .cout(cout_v[5]));

  assign sum_w[0] = {8'h00, s0};
  assign sum_w[1] = {8'h00, s1};
  assign sum_w[2] = s2;
  assign sum_w[3] = {4'h0, s3};
  assign sum_w[4] = {8'h00, s4};
  assign sum_w[5] = {8'h00, s5};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete op on instance k; checks busy (optional), latency, result and done width.
  task automatic run_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input bit chk_busy, input string tag);
    logic [16:0] full;
    logic [15:0] mask;
    int          cyc;
    mask = 16'((17'h1 << wid[k]) - 17'h1);
    full = 17'(av & mask) + 17'(bv & mask) + 17'(cv);
    a_i = av; b_i = bv; cin_i = cv; start_v[k] = 1'b1;
    tick();
    start_v[k] = 1'b0;
    // Scramble inputs: the op in flight must not notice.
    a_i = ~av; b_i = ~bv; cin_i = ~cv;
    cyc = 0;
    while (!done_v[k] && cyc < 64) begin
      if (chk_busy) check_eq({tag, "_busy"}, 32'(busy_v[k]), 32'd1);
      tick();
      cyc++;
    end
    check_eq({tag, "_lat"}, cyc, nch[k]);
    check_eq({tag, "_sum"}, 32'(sum_w[k]), 32'(full[15:0] & mask));
    check_eq({tag, "_cout"}, 32'(cout_v[k]), 32'(full[wid[k]]));
    if (chk_busy) check_eq({tag, "_busy_at_done"}, 32'(busy_v[k]), 32'd0);
    tick();
    check_eq({tag, "_done_pulse"}, 32'(done_v[k]), 32'd0);
  endtask

  initial begin
    int cyc;
    int nd;
    rst_n = 1'b0; start_v = '0; a_i = '0; b_i = '0; cin_i = 1'b0;
    #2;
    check_eq("rst_busy", 32'(busy_v[0]), 32'd0);
    check_eq("rst_done", 32'(done_v[0]), 32'd0);
    check_eq("rst_sum", 32'(sum_w[3]), 32'd0);
    check_eq("rst_cout", 32'(cout_v[3]), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Directed vectors
    run_op(0, 16'h0000, 16'h0000, 1'b0, 1'b1, "zero");      // 0x00, cout 0
    run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b1, "wrap");      // 0x00, cout 1
    run_op(0, 16'h007F, 16'h0001, 1'b0, 1'b1, "7f_plus1"); // 0x80, cout 0
    run_op(1, 16'h005A, 16'h00A5, 1'b1, 1'b1, "c4");        // 0x00, cout 1, lat 2
    run_op(2, 16'h1234, 16'h4321, 1'b0, 1'b1, "c16");       // 0x5555, lat 1
    run_op(3, 16'h0FFF, 16'h0000, 1'b1, 1'b1, "c3_carry");  // 0x000, cout 1

    // start re-pulsed mid-RUN with other operands: ignored, one done, 0x0F+0x01=0x10
    a_i = 16'h000F; b_i = 16'h0001; cin_i = 1'b0; start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick(); tick();
    a_i = 16'h00AA; b_i = 16'h0055; cin_i = 1'b1; start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (done_v[0]) nd++;
      tick();
    end
    check_eq("midrun_ndone", nd, 1);
    check_eq("midrun_sum", 32'(sum_w[0]), 32'h10);
    check_eq("midrun_cout", 32'(cout_v[0]), 32'd0);

    // start held across DONE: second op accepted on the DONE edge
    a_i = 16'h0003; b_i = 16'h0004; cin_i = 1'b0; start_v[0] = 1'b1;
    tick();
    a_i = 16'h0010; b_i = 16'h0020;
    cyc = 0;
    while (!done_v[0] && cyc < 64) begin tick(); cyc++; end
    check_eq("b2b_lat1", cyc, 8);
    check_eq("b2b_sum1", 32'(sum_w[0]), 32'h07);
    tick();
    start_v[0] = 1'b0;
    check_eq("b2b_busy2", 32'(busy_v[0]), 32'd1);
    check_eq("b2b_done_low", 32'(done_v[0]), 32'd0);
    cyc = 0;
    while (!done_v[0] && cyc < 64) begin tick(); cyc++; end
    // 8 more edges after the accept edge = NCH+1 after the first done
    check_eq("b2b_lat2", cyc, 8);
    check_eq("b2b_sum2", 32'(sum_w[0]), 32'h30);
    tick();

    // Reset in the middle of a run: 0x05+0x02, two bits processed -> partial 0x03
    a_i = 16'h0005; b_i = 16'h0002; cin_i = 1'b0; start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick(); tick();
    check_eq("abort_partial", 32'(sum_w[0]), 32'h03);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 32'(busy_v[0]), 32'd0);
    check_eq("abort_done", 32'(done_v[0]), 32'd0);
    check_eq("abort_sum", 32'(sum_w[0]), 32'd0);
    check_eq("abort_cout", 32'(cout_v[0]), 32'd0);
    nd = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done_v[0]) nd++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done_v[0]) nd++;
    end
    check_eq("abort_no_done", nd, 0);
    run_op(0, 16'h0012, 16'h0034, 1'b1, 1'b1, "after_rst"); // 0x47

    // Random sweep against a+b+cin
    for (int r = 0; r < 40; r++) begin
      run_op(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, "rnd_8_1");
      run_op(4, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, "rnd_8_2");
      run_op(5, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, "rnd_8_8");
      run_op(3, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, "rnd_12_3");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
